ttl_74148_irq: RTL and testbench
================================

Name: ttl_74148_irq

Overview:
- Clocked 8-input priority encoder with request latching and acknowledge handshake; the encoding counterpart of the 74138 3-to-8 decoder.
- Captures active-low request lines and presents the highest-priority pending request as an active-low 3-bit code with 74148-style GS_n/EO_n pins.
- Holds the presented code until acknowledged.
- Sits between TTL-modelled peripheral request lines and a CPU interrupt/vector input, so a decoded select bus can be encoded back to a vector.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per request line; legal range 1..3.
- LEVEL, 0, 0 = falling-edge-triggered requests (latched); 1 = level-sensitive (pending mirrors the synchronized line).

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- I_n  input  8  request lines, active low; bit 7 highest priority.
- EI_n  input  1  enable input, active low.
- ACK  input  1  acknowledge from consumer, active high.
- A_n  output  3  active-low encoded index of the presented request.
- GS_n  output  1  group select, active low; a code is being presented.
- EO_n  output  1  enable output, active low; enabled and nothing pending (cascade to lower-priority encoder).
- PENDING  output  8  active-high pending request bits, for debug/verification.

Behaviour:
- Reset (synchronous, reset=1 at a rising clk edge):
  - synchronizer flops = 1, pending = 0, state = IDLE.
  - A_n = 3'b111, GS_n = 1, EO_n = 1.
  - Reset mid-PRESENT/HOLD discards the code and all pending requests.
- Synchronizer: each I_n bit passes through SYNC_STAGES flops; sync_n is the last stage.
- Edge detect (LEVEL=0): fall[i] = previous sync_n[i] & ~sync_n[i]; fall sets pending[i].
- LEVEL=1: pending[i] = ~sync_n[i] every cycle; ACK clear has no lasting effect while the line stays low.
- Latency:
  - A request low at clk edge k sets pending at edge k+SYNC_STAGES.
  - GS_n/A_n update at edge k+SYNC_STAGES+1 (default: 3 clocks).
- Priority: highest set pending bit wins; code = index; A_n = ~index.
- State machine:
  - IDLE: if EI_n=0 and pending!=0, latch idx = highest pending, drive A_n=~idx and GS_n=0, go to PRESENT; otherwise stay.
  - PRESENT:
    - A_n is frozen even if a higher-priority request arrives.
    - ACK=1: clear pending[idx], drive GS_n=1 and A_n=111, go to HOLD.
    - EI_n=1 (with ACK=0): abort to IDLE, pending unchanged, drive GS_n=1 and A_n=111.
    - If ACK=1 and EI_n=1 in the same cycle, ACK wins.
  - HOLD: wait for ACK=0, then go to IDLE. A new code is presented no earlier than the edge after return to IDLE, so one ACK pulse clears exactly one request.
- Simultaneous set and clear on the same bit in one cycle: set wins, pending stays 1.
- EO_n: registered; 0 only when EI_n=0, state=IDLE and pending=0 (evaluated on the values at that edge); otherwise 1.
- All outputs are registered; no combinational path from inputs to outputs.
- Pending capture continues in every state and regardless of EI_n.

Test Plan:
- Reset, then idle with I_n=FF, EI_n=0 -> A_n=111, GS_n=1, EO_n=0, PENDING=00.
- With EI_n=0, pulse I_n[5] low for 1 clk -> PENDING=20 after 2 clks; next edge A_n=010, GS_n=1→0, EO_n=1. ACK pulse -> PENDING=00, GS_n=1, then EO_n=0 after ACK drops.
- I_n[2] and I_n[6] fall in the same cycle -> A_n=001 (idx 6). After ACK, A_n=101 (idx 2). After second ACK, EO_n=0.
- While presenting idx 3, I_n[7] falls -> A_n stays 100 until ACK; after ACK/HOLD, A_n=000.
- EI_n=1 with I_n[4] pulsed -> PENDING=10, GS_n=1, EO_n=1. EI_n→0 -> A_n=011, GS_n=0 one edge later.
- Assert reset while in PRESENT with PENDING=81 -> next edge PENDING=00, A_n=111, GS_n=1, EO_n=1. ACK held high across reset causes no action.

Source files
------------

// File: rtl/ttl_74148_irq.sv
// Clocked 8-input priority encoder (74148-style pins). Requests are synchronized
// and latched, and the presented code is held until the consumer acknowledges it.
module ttl_74148_irq #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          LEVEL       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] I_n,
  input  logic       EI_n,
  input  logic       ACK,
  output logic [2:0] A_n,
  output logic       GS_n,
  output logic       EO_n,
  output logic [7:0] PENDING
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned IW   = 3;

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   sync_q [SYNC_STAGES];
  logic [NREQ-1:0]   sync_n;
  logic [NREQ-1:0]   prev_q;
  logic [NREQ-1:0]   fall;
  logic [NREQ-1:0]   clr;
  logic [NREQ-1:0]   pend_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     a_n_d;
  logic              gs_n_d;
  logic              eo_n_d;

  function automatic logic [IW-1:0] top_idx(input logic [NREQ-1:0] v);
    top_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (v[i]) top_idx = IW'(i);
    end
  endfunction

  // Request synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      prev_q <= '1;
    end else begin
      sync_q[0] <= I_n;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_n;
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];
  assign fall   = prev_q & ~sync_n;
  // A new edge on the bit being acknowledged survives the clear.
  assign pend_d = LEVEL ? ~sync_n : ((PENDING & ~clr) | fall);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!EI_n && (|PENDING)) state_d = PRESENT;
      PRESENT: if (ACK) state_d = HOLD;
               else if (EI_n) state_d = IDLE;
      HOLD:    if (!ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_n_d  = '1;
    gs_n_d = 1'b1;
    idx_d  = idx_q;
    clr    = '0;
    case (state_q)
      IDLE: begin
        if (!EI_n && (|PENDING)) begin
          idx_d  = top_idx(PENDING);
          a_n_d  = ~top_idx(PENDING);
          gs_n_d = 1'b0;
        end
      end
      PRESENT: begin
        if (ACK) begin
          clr = NREQ'(1) << idx_q;
        end else if (!EI_n) begin
          a_n_d  = ~idx_q;
          gs_n_d = 1'b0;
        end
      end
      default: ;
    endcase
    eo_n_d = ~(~EI_n & (state_q == IDLE) & ~(|PENDING));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A_n     <= '1;
      GS_n    <= 1'b1;
      EO_n    <= 1'b1;
      PENDING <= '0;
      idx_q   <= '0;
    end else begin
      A_n     <= a_n_d;
      GS_n    <= gs_n_d;
      EO_n    <= eo_n_d;
      PENDING <= pend_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_ttl_74148_irq.sv
// Bench for ttl_74148_irq: directed vector table followed by randomized traffic
// checked against a cycle-level reference model.
module tb_ttl_74148_irq;

  localparam int unsigned S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] I_n;
  logic       EI_n;
  logic       ACK;
  logic [2:0] A_n;
  logic       GS_n;
  logic       EO_n;
  logic [7:0] PENDING;

  int checks = 0;
  int errors = 0;

  ttl_74148_irq #(.SYNC_STAGES(S), .LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .I_n(I_n), .EI_n(EI_n), .ACK(ACK),
    .A_n(A_n), .GS_n(GS_n), .EO_n(EO_n), .PENDING(PENDING)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] i_n;
    logic       ei_n;
    logic       ack;
    logic [2:0] a_n;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[$];

  // Reference model: input history, pending bits, and whether a code is shown.
  logic [7:0] h [0:S];
  logic [7:0] m_pend;
  bit         m_pres, m_hold;
  int         m_code;
  logic [2:0] m_a;
  logic       m_gs, m_eo;

  task automatic model_step();
    logic [7:0] fall, clr;
    if (reset) begin
      for (int j = 0; j <= S; j++) h[j] = 8'hFF;
      m_pend = 8'h00; m_pres = 0; m_hold = 0; m_code = 0;
      m_a = 3'b111; m_gs = 1'b1; m_eo = 1'b1;
      return;
    end
    fall = h[S] & ~h[S-1];
    m_eo = !(EI_n == 1'b0 && !m_pres && !m_hold && m_pend == 8'h00);
    clr  = 8'h00;
    if (m_pres) begin
      if (ACK) begin clr[m_code] = 1'b1; m_pres = 0; m_hold = 1; end
      else if (EI_n) m_pres = 0;
    end else if (m_hold) begin
      if (!ACK) m_hold = 0;
    end else if (!EI_n && m_pend != 8'h00) begin
      for (int i = 0; i < 8; i++) if (m_pend[i]) m_code = i;
      m_pres = 1;
    end
    m_pend = (m_pend & ~clr) | fall;
    for (int j = S; j >= 1; j--) h[j] = h[j-1];
    h[0] = I_n;
    m_a  = m_pres ? 3'(7 - m_code) : 3'b111;
    m_gs = !m_pres;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic add(input logic r, input logic [7:0] i, input logic ei, input logic ak,
                     input logic [2:0] a, input logic gs, input logic eo, input logic [7:0] p);
    vec_t v;
    v.rst = r; v.i_n = i; v.ei_n = ei; v.ack = ak;
    v.a_n = a; v.gs_n = gs; v.eo_n = eo; v.pend = p;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b1; I_n = 8'hFF; EI_n = 1'b0; ACK = 1'b0;
    // reset and idle
    add(1, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    // single request on bit 5
    add(0, 8'hDF, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h20);
    add(0, 8'hFF, 0, 0, 3'd2, 0, 1, 8'h20);
    add(0, 8'hFF, 0, 1, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    // bits 2 and 6 together
    add(0, 8'hBB, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h44);
    add(0, 8'hFF, 0, 0, 3'd1, 0, 1, 8'h44);
    add(0, 8'hFF, 0, 1, 3'd7, 1, 1, 8'h04);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h04);
    add(0, 8'hFF, 0, 0, 3'd5, 0, 1, 8'h04);
    add(0, 8'hFF, 0, 1, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    // bit 7 arrives while bit 3 is presented
    add(0, 8'hF7, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h08);
    add(0, 8'h7F, 0, 0, 3'd4, 0, 1, 8'h08);
    add(0, 8'hFF, 0, 0, 3'd4, 0, 1, 8'h08);
    add(0, 8'hFF, 0, 0, 3'd4, 0, 1, 8'h88);
    add(0, 8'hFF, 0, 0, 3'd4, 0, 1, 8'h88);
    add(0, 8'hFF, 0, 1, 3'd7, 1, 1, 8'h80);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h80);
    add(0, 8'hFF, 0, 0, 3'd0, 0, 1, 8'h80);
    add(0, 8'hFF, 0, 1, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    // request captured while disabled, presented once enabled
    add(0, 8'hEF, 1, 0, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 1, 0, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 1, 0, 3'd7, 1, 1, 8'h10);
    add(0, 8'hFF, 1, 0, 3'd7, 1, 1, 8'h10);
    add(0, 8'hFF, 0, 0, 3'd3, 0, 1, 8'h10);
    add(0, 8'hFF, 0, 1, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    // abort by EI_n, re-present, then ACK beats EI_n
    add(0, 8'hFD, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h02);
    add(0, 8'hFF, 0, 0, 3'd6, 0, 1, 8'h02);
    add(0, 8'hFF, 1, 0, 3'd7, 1, 1, 8'h02);
    add(0, 8'hFF, 0, 0, 3'd6, 0, 1, 8'h02);
    add(0, 8'hFF, 1, 1, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 1, 8'h00);
    // reset while presenting with pending 81, ACK held across reset
    add(0, 8'h7E, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h81);
    add(0, 8'hFF, 0, 0, 3'd0, 0, 1, 8'h81);
    add(1, 8'hFF, 0, 1, 3'd7, 1, 1, 8'h00);
    add(0, 8'hFF, 0, 1, 3'd7, 1, 0, 8'h00);
    add(0, 8'hFF, 0, 0, 3'd7, 1, 0, 8'h00);

    foreach (vecs[n]) begin
      reset = vecs[n].rst; I_n = vecs[n].i_n; EI_n = vecs[n].ei_n; ACK = vecs[n].ack;
      tick();
      checks++;
      if (A_n !== vecs[n].a_n || GS_n !== vecs[n].gs_n ||
          EO_n !== vecs[n].eo_n || PENDING !== vecs[n].pend) begin
        errors++;
        $display("FAIL vec%0d got A_n=%b GS_n=%b EO_n=%b PENDING=%h want A_n=%b GS_n=%b EO_n=%b PENDING=%h",
                 n, A_n, GS_n, EO_n, PENDING, vecs[n].a_n, vecs[n].gs_n, vecs[n].eo_n, vecs[n].pend);
      end
    end

    // randomized traffic against the reference model
    reset = 1'b1; I_n = 8'hFF; EI_n = 1'b0; ACK = 1'b0;
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] v;
      v = 8'hFF;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) v[b] = 1'b0;
      reset = ($urandom_range(0, 299) == 0);
      I_n   = v;
      EI_n  = ($urandom_range(0, 7) == 0);
      ACK   = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (A_n !== m_a || GS_n !== m_gs || EO_n !== m_eo || PENDING !== m_pend) begin
        errors++;
        $display("FAIL rand%0d got A_n=%b GS_n=%b EO_n=%b PENDING=%h want A_n=%b GS_n=%b EO_n=%b PENDING=%h",
                 c, A_n, GS_n, EO_n, PENDING, m_a, m_gs, m_eo, m_pend);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
